// File: rtl/sipo_pkg.sv
// Shared definitions for the serial-in/parallel-out block.
//   LSB_FIRST_MODE / MSB_FIRST_MODE : bit-order selectors for sipo_param.LSB_FIRST
//   cnt_width()                     : width of the partial-word bit counter
package sipo_pkg;

   localparam int unsigned LSB_FIRST_MODE = 1;
   localparam int unsigned MSB_FIRST_MODE = 0;

   // A WIDTH-bit word needs counts 0..WIDTH-1; WIDTH >= 2 keeps this >= 1.
   function automatic int unsigned cnt_width(input int unsigned width);
      return $clog2(width);
   endfunction

endpackage

// File: rtl/sipo_param_mod_counter.sv
// Modulo-N up counter with enable, synchronous clear and wrap flag.
//   clk      : clock, rising edge
//   rst      : asynchronous active-high reset (count -> 0)
//   en_i     : advance the count this cycle
//   clr_i    : synchronous clear, overrides en_i
//   count_o  : current count, 0..MODULUS-1
//   wrap_o   : en_i while count is MODULUS-1 (count returns to 0 next edge)
module mod_counter #(
   parameter int unsigned MODULUS = 8,
   parameter int unsigned W       = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en_i,
   input  logic         clr_i,
   output logic [W-1:0] count_o,
   output logic         wrap_o
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;
   logic         at_max;

   always_comb begin
      at_max  = (count_q == W'(MODULUS - 1));
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (en_i) begin
         count_d = at_max ? '0 : count_q + W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;
   assign wrap_o  = en_i && !clr_i && at_max;

endmodule

// File: rtl/sipo_param.sv
// Serial-in / parallel-out assembler with valid/ready on both sides.
//   clk      : clock, rising edge
//   rst      : asynchronous active-high reset
//   ser_in   : serial data bit
//   in_valid : ser_in carries a bit; accepted when in_ready is also high
//   in_ready : bit accepted this cycle (only the final bit can be stalled)
//   clr      : synchronous abort of the partial word (q/q_valid untouched)
//   q        : assembled word, registered
//   q_valid  : q holds an unconsumed word
//   q_ready  : consumer takes q this cycle
//   cnt      : bits collected for the current partial word
module sipo_param
   import sipo_pkg::*;
#(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned LSB_FIRST = LSB_FIRST_MODE
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          ser_in,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic                          clr,
   output logic [WIDTH-1:0]              q,
   output logic                          q_valid,
   input  logic                          q_ready,
   output logic [cnt_width(WIDTH)-1:0]   cnt
);

   localparam int unsigned CW = cnt_width(WIDTH);

   logic [WIDTH-1:0] sr_q;
   logic [WIDTH-1:0] sr_d;
   logic [WIDTH-1:0] shifted;
   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] q_d;
   logic             q_valid_q;
   logic             q_valid_d;
   logic [CW-1:0]    cnt_w;
   logic             accept;
   logic             consume;
   logic             load;
   logic             ready_w;

   // Only the final bit needs a free output slot; earlier bits always fit.
   always_comb begin
      ready_w = !clr && ((cnt_w != CW'(WIDTH - 1)) || !q_valid_q || q_ready);
      accept  = in_valid && ready_w;
      consume = q_valid_q && q_ready;
   end

   mod_counter #(
      .MODULUS (WIDTH),
      .W       (CW)
   ) u_cnt (
      .clk     (clk),
      .rst     (rst),
      .en_i    (accept),
      .clr_i   (clr),
      .count_o (cnt_w),
      .wrap_o  (load)
   );

   always_comb begin
      if (LSB_FIRST == LSB_FIRST_MODE) begin
         shifted = {ser_in, sr_q[WIDTH-1:1]};
      end else begin
         shifted = {sr_q[WIDTH-2:0], ser_in};
      end
   end

   always_comb begin
      sr_d      = sr_q;
      q_d       = q_q;
      q_valid_d = q_valid_q;
      if (clr) begin
         sr_d = '0;
      end else if (accept) begin
         sr_d = shifted;
      end
      // Load wins over consume so a back-to-back word leaves no bubble.
      if (load) begin
         q_d       = shifted;
         q_valid_d = 1'b1;
      end else if (consume) begin
         q_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sr_q      <= '0;
         q_q       <= '0;
         q_valid_q <= 1'b0;
      end else begin
         sr_q      <= sr_d;
         q_q       <= q_d;
         q_valid_q <= q_valid_d;
      end
   end

   assign in_ready = ready_w;
   assign q        = q_q;
   assign q_valid  = q_valid_q;
   assign cnt      = cnt_w;

endmodule

// File: tb/tb_sipo_param.sv
module tb_sipo_param;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       ser_l, iv_l, clr_l, qr_l, ir_l, qv_l;
   logic [7:0] q_l;
   logic [2:0] cnt_l;
   logic       ser_m, iv_m, clr_m, qr_m, ir_m, qv_m;
   logic [7:0] q_m;
   logic [2:0] cnt_m;

   int n_cmp  = 0;
   int n_fail = 0;
   logic [7:0] exp_l[$];
   logic [7:0] exp_m[$];
   bit done = 1'b0;

   sipo_param #(.WIDTH(8), .LSB_FIRST(1)) dut_l (
      .clk(clk), .rst(rst), .ser_in(ser_l), .in_valid(iv_l), .in_ready(ir_l),
      .clr(clr_l), .q(q_l), .q_valid(qv_l), .q_ready(qr_l), .cnt(cnt_l)
   );

   sipo_param #(.WIDTH(8), .LSB_FIRST(0)) dut_m (
      .clk(clk), .rst(rst), .ser_in(ser_m), .in_valid(iv_m), .in_ready(ir_m),
      .clr(clr_m), .q(q_m), .q_valid(qv_m), .q_ready(qr_m), .cnt(cnt_m)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitors: pop the expected word whenever the DUT hands one over.
   logic       hold_l = 1'b0;
   logic [7:0] hold_q;
   always @(negedge clk) begin
      if (rst) begin
         hold_l = 1'b0;
      end else begin
         if (hold_l) check("q_stable_l", q_l, hold_q);
         if (qv_l && qr_l) begin
            if (exp_l.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL extra_word_l: got %0h expected none at %0t", q_l, $time);
            end else begin
               check("word_l", q_l, exp_l.pop_front());
            end
         end
         hold_l = qv_l && !qr_l;
         hold_q = q_l;
      end
   end

   always @(negedge clk) begin
      if (!rst && qv_m && qr_m) begin
         if (exp_m.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL extra_word_m: got %0h expected none at %0t", q_m, $time);
         end else begin
            check("word_m", q_m, exp_m.pop_front());
         end
      end
   end

   // Offer one bit; returns at posedge+1 of the accepting edge.
   task automatic send_bit_l(input logic b, input int unsigned gap);
      int unsigned waited = 0;
      iv_l = 1'b0;
      repeat (gap) begin
         @(posedge clk);
         #1;
      end
      ser_l = b;
      iv_l  = 1'b1;
      forever begin
         @(negedge clk);
         if (ir_l) break;
         waited++;
         if (waited > 200) begin
            n_cmp++;
            n_fail++;
            $display("FAIL accept_timeout_l: got in_ready=0 expected 1 within 200 cycles");
            break;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send_word_l(input logic [7:0] w, input bit push);
      if (push) exp_l.push_back(w);
      for (int i = 0; i < 8; i++) send_bit_l(w[i], 0);
      iv_l = 1'b0;
   endtask

   task automatic send_word_m(input logic [7:0] w);
      int unsigned waited;
      exp_m.push_back(w);
      for (int i = 7; i >= 0; i--) begin
         ser_m  = w[i];
         iv_m   = 1'b1;
         waited = 0;
         forever begin
            @(negedge clk);
            if (ir_m) break;
            waited++;
            if (waited > 200) begin
               n_cmp++;
               n_fail++;
               $display("FAIL accept_timeout_m: got in_ready=0 expected 1 within 200 cycles");
               break;
            end
         end
         @(posedge clk);
         #1;
      end
      iv_m = 1'b0;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] v;
      logic [7:0] w;
      int unsigned drain;

      rst = 1'b1;
      ser_l = 1'b0; iv_l = 1'b0; clr_l = 1'b0; qr_l = 1'b1;
      ser_m = 1'b0; iv_m = 1'b0; clr_m = 1'b0; qr_m = 1'b1;

      // Reset state, and bits offered during reset are ignored.
      #2;
      check("rst_q", q_l, 8'h00);
      check("rst_q_valid", qv_l, 1'b0);
      check("rst_cnt", cnt_l, 3'd0);
      check("rst_in_ready", ir_l, 1'b1);
      check("rst_q_valid_m", qv_m, 1'b0);
      iv_l = 1'b1;
      ser_l = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_ignore_cnt", cnt_l, 3'd0);
      iv_l = 1'b0;
      rst  = 1'b0;
      @(posedge clk);
      #1;
      check("post_rst_cnt", cnt_l, 3'd0);

      // LSB-first basic word: 1,0,1,1,0,0,1,0 -> 4D.
      send_word_l(8'h4D, 1'b1);
      check("lsb_q", q_l, 8'h4D);
      check("lsb_q_valid", qv_l, 1'b1);
      check("lsb_cnt", cnt_l, 3'd0);
      @(posedge clk);
      #1;
      check("lsb_q_valid_one_cycle", qv_l, 1'b0);

      // MSB-first: same bit stream -> B2.
      send_word_m(8'hB2);
      check("msb_q", q_m, 8'hB2);
      check("msb_q_valid", qv_m, 1'b1);
      @(posedge clk);
      #1;
      check("msb_q_valid_one_cycle", qv_m, 1'b0);

      // Back-pressure on the final bit only; release gives a bubble-free swap.
      qr_l = 1'b0;
      send_word_l(8'h4D, 1'b1);
      v = 8'hB2;
      exp_l.push_back(v);
      for (int i = 0; i < 7; i++) begin
         #1;
         check("bp_in_ready_partial", ir_l, 1'b1);
         send_bit_l(v[i], 0);
      end
      ser_l = v[7];
      iv_l  = 1'b1;
      @(negedge clk);
      check("bp_in_ready_final", ir_l, 1'b0);
      check("bp_cnt", cnt_l, 3'd7);
      @(negedge clk);
      check("bp_q_held", q_l, 8'h4D);
      @(posedge clk);
      #1;
      qr_l = 1'b1;
      @(posedge clk);
      #1;
      iv_l = 1'b0;
      check("bp_swap_q", q_l, 8'hB2);
      check("bp_swap_q_valid", qv_l, 1'b1);
      check("bp_swap_cnt", cnt_l, 3'd0);
      @(posedge clk);
      #1;

      // Abort a partial word with clr while a word is held.
      qr_l = 1'b0;
      send_word_l(8'h3C, 1'b1);
      for (int i = 0; i < 3; i++) send_bit_l(1'b1, 0);
      iv_l  = 1'b0;
      clr_l = 1'b1;
      #1;
      check("clr_in_ready", ir_l, 1'b0);
      @(posedge clk);
      #1;
      clr_l = 1'b0;
      check("clr_cnt", cnt_l, 3'd0);
      check("clr_q_valid", qv_l, 1'b1);
      check("clr_q", q_l, 8'h3C);
      qr_l = 1'b1;
      send_word_l(8'hA5, 1'b1);
      check("clr_next_word", q_l, 8'hA5);
      @(posedge clk);
      #1;

      // Asynchronous reset mid-word with a held word.
      qr_l = 1'b0;
      send_word_l(8'h5A, 1'b1);
      send_bit_l(1'b1, 0);
      send_bit_l(1'b0, 0);
      send_bit_l(1'b1, 0);
      send_bit_l(1'b0, 0);
      send_bit_l(1'b1, 0);
      iv_l = 1'b0;
      check("arst_pre_cnt", cnt_l, 3'd5);
      #2;
      rst = 1'b1;
      #1;
      check("arst_q", q_l, 8'h00);
      check("arst_q_valid", qv_l, 1'b0);
      check("arst_cnt", cnt_l, 3'd0);
      check("arst_in_ready", ir_l, 1'b1);
      exp_l.delete();
      @(posedge clk);
      #1;
      rst  = 1'b0;
      qr_l = 1'b1;
      send_word_l(8'hC3, 1'b1);
      check("arst_next_word", q_l, 8'hC3);
      @(posedge clk);
      #1;

      // Long run with random gaps on both sides.
      fork
         begin
            for (int n = 0; n < 1000; n++) begin
               w = 8'($urandom);
               exp_l.push_back(w);
               for (int i = 0; i < 8; i++)
                  send_bit_l(w[i], ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
               iv_l = 1'b0;
            end
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge clk);
               #1;
               qr_l = ($urandom_range(0, 3) != 0);
            end
         end
      join
      qr_l  = 1'b1;
      drain = 0;
      while (exp_l.size() != 0 && drain < 50) begin
         @(posedge clk);
         drain++;
      end
      @(negedge clk);
      check("sb_drained_l", exp_l.size(), 0);
      check("sb_drained_m", exp_m.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/sipo_param.md
SIPO_PARAM -- requirements
Module: sipo_param

Interface
REQ-001 Parameter WIDTH, default 8, parallel word width in bits; SHALL be >= 2.
REQ-002 Parameter LSB_FIRST, default 1; 1 = first received bit lands in q[0], 0 = first received bit lands in q[WIDTH-1].
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 ser_in  input  1  serial data bit.
REQ-006 in_valid  input  1  ser_in carries a bit this cycle.
REQ-007 in_ready  output  1  block accepts the bit this cycle; accept = in_valid && in_ready.
REQ-008 clr  input  1  synchronous abort of the partially assembled word.
REQ-009 q  output  WIDTH  assembled parallel word, registered.
REQ-010 q_valid  output  1  q holds an unconsumed word.
REQ-011 q_ready  input  1  consumer takes q this cycle; consume = q_valid && q_ready.
REQ-012 cnt  output  $clog2(WIDTH)  number of bits of the current partial word, 0..WIDTH-1.

Function
REQ-013 Internal shift register sr (WIDTH bits) SHALL change only on accept or clr; in_valid bubbles SHALL NOT shift.
REQ-014 On accept with LSB_FIRST=1, sr SHALL become {ser_in, sr[WIDTH-1:1]}; with LSB_FIRST=0, {sr[WIDTH-2:0], ser_in}.
REQ-015 On accept with cnt < WIDTH-1, cnt SHALL increment by 1.
REQ-016 On accept with cnt == WIDTH-1 (final bit), the complete word including ser_in SHALL be loaded into q, q_valid SHALL be 1 next cycle, cnt SHALL wrap to 0.
REQ-017 Latency: q/q_valid SHALL reflect the word in the cycle after the final bit is accepted.
REQ-018 in_ready SHALL be 1 when cnt != WIDTH-1, or !q_valid, or q_ready; otherwise 0 (only the final bit is back-pressured).
REQ-019 in_ready SHALL be 0 while clr is 1.
REQ-020 Consume without simultaneous load SHALL clear q_valid next cycle; q unchanged.
REQ-021 Simultaneous consume and load SHALL keep q_valid 1 and replace q with the new word, no bubble.
REQ-022 While q_valid && !q_ready, q SHALL remain stable.
REQ-023 clr SHALL set cnt and sr to 0 next cycle, SHALL take priority over accept, and SHALL NOT affect q or q_valid.
REQ-024 No word SHALL be lost or duplicated under any interleaving of in_valid, q_ready, clr.

Reset
REQ-025 rst asserted SHALL immediately, without a clock edge, force sr=0, cnt=0, q=0, q_valid=0.
REQ-026 Reset mid-word SHALL discard the partial word; first accept after release starts a new word at bit 0.
REQ-027 in_ready SHALL be 1 during and after reset (cnt=0); bits offered while rst=1 SHALL be ignored.

Structure
REQ-028 Shared package sipo_pkg SHALL hold localparams LSB_FIRST_MODE=1, MSB_FIRST_MODE=0, and a function for the cnt width from WIDTH.
REQ-029 The bit counter SHALL be a sub-module mod_counter (parametrised modulus, enable, sync clear, async active-high reset, wrap flag).
REQ-030 Shift path, output register and handshake logic SHALL live in sipo_param; no combinational path from q_ready to q.

Verification (WIDTH=8)
REQ-031 LSB_FIRST=1, q_ready=1, bits 1,0,1,1,0,0,1,0 on consecutive cycles -> next cycle q=8'h4D, q_valid=1 for one cycle, cnt=0.
REQ-032 LSB_FIRST=0, same stream -> q=8'hB2, q_valid=1 for one cycle.
REQ-033 q_ready=0 holding 8'h4D, stream second word 8'hB2 -> in_ready=1 for 7 bits, 0 at cnt=7, q stays 8'h4D; raise q_ready -> final bit accepted same cycle, next cycle q=8'hB2, q_valid stays 1.
REQ-034 3 bits accepted, then clr for one cycle, then 8 bits of 8'hA5 -> q=8'hA5 exactly, no stale bits; q_valid unaffected by clr.
REQ-035 rst pulsed between clock edges at cnt=5 with q_valid=1 -> q=0, q_valid=0, cnt=0 immediately; next 8 bits yield one correct word.
REQ-036 Random in_valid/q_ready gaps, 1000 words -> scoreboard matches every word in order, none lost or duplicated.
